// File: rtl/collision_pkg.sv
// Shared types and widths for the player/tower collision block.
package collision_pkg;

    typedef enum logic [1:0] {
        ALIVE     = 2'd0,
        COOLDOWN  = 2'd1,
        GAME_OVER = 2'd2
    } collision_state_t;

    localparam int LIVES_W     = 4;
    localparam int HIT_CNT_W   = 8;
    localparam int TIMER_W     = 10;
    localparam int OVL_CNT_W   = 8;
    localparam int HIT_CNT_MAX = 255;

    // Saturating increment for the hit counter.
    function automatic logic [HIT_CNT_W-1:0] hit_cnt_inc(input logic [HIT_CNT_W-1:0] v);
        if (v == HIT_CNT_W'(HIT_CNT_MAX)) begin
            return v;
        end
        return v + 1'b1;
    endfunction

endpackage

// File: rtl/frame_overlap_counter.sv
// Per-frame player/tower coincidence counter.
// Counts overlapping pixels, saturating at the hit threshold, and emits a
// one-cycle frameHit pulse in the cycle after startOfFrame when the frame
// that just ended reached the threshold. An overlap coinciding with
// startOfFrame belongs to the new frame. restart clears everything.
module frame_overlap_counter
    import collision_pkg::*;
#(
    parameter int MIN_OVERLAP_PIXELS = 4
)
(
    input  logic clk,
    input  logic resetN,
    input  logic startOfFrame,
    input  logic playerDrawingRequest,
    input  logic towerDrawingRequest,
    input  logic restart,
    output logic frameHit
);

    localparam logic [OVL_CNT_W-1:0] MIN_CNT = OVL_CNT_W'(MIN_OVERLAP_PIXELS);
    localparam logic [OVL_CNT_W-1:0] ONE_CNT = OVL_CNT_W'(1);

    logic [OVL_CNT_W-1:0] ovl_cnt;
    logic                 overlap;

    assign overlap = playerDrawingRequest && towerDrawingRequest;

    // Counter and frame-boundary evaluation; restart wins over startOfFrame.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            ovl_cnt  <= '0;
            frameHit <= 1'b0;
        end else if (restart) begin
            ovl_cnt  <= '0;
            frameHit <= 1'b0;
        end else if (startOfFrame) begin
            frameHit <= (ovl_cnt >= MIN_CNT);
            ovl_cnt  <= overlap ? ONE_CNT : '0;
        end else begin
            frameHit <= 1'b0;
            if (overlap && (ovl_cnt < MIN_CNT)) begin
                ovl_cnt <= ovl_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/player_tower_collision.sv
// Player/tower collision, lives and invulnerability controller.
// Optional build macro: COLLISION_BLINK_EN (blink playerVisible during cooldown).
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ALIVE     | hits from the previous frame are evaluated after each SOF
// COOLDOWN  | invulnerable; frame timer counts down on unpaused SOFs
// GAME_OVER | no lives left; waits for restart
module player_tower_collision
    import collision_pkg::*;
#(
    parameter int LIVES_INIT         = 3,
    parameter int MIN_OVERLAP_PIXELS = 4,
    parameter int INVULN_FRAMES      = 60,
    parameter int BLINK_PERIOD       = 8
)
(
    input  logic                 clk,
    input  logic                 resetN,
    input  logic                 startOfFrame,
    input  logic                 playerDrawingRequest,
    input  logic                 towerDrawingRequest,
    input  logic                 pause,
    input  logic                 restart,
    output logic                 collision,
    output logic [LIVES_W-1:0]   livesLeft,
    output logic [HIT_CNT_W-1:0] hitCount,
    output logic                 invulnerable,
    output logic                 gameOver,
    output logic                 playerVisible
);

    localparam logic [LIVES_W-1:0] LIVES_LOAD  = LIVES_W'(LIVES_INIT);
    localparam logic [TIMER_W-1:0] TIMER_LOAD  = TIMER_W'(INVULN_FRAMES);
    localparam logic [TIMER_W-1:0] TIMER_ONE   = TIMER_W'(1);
    localparam logic [LIVES_W-1:0] LIVES_ONE   = LIVES_W'(1);

    collision_state_t     state, state_nxt;
    logic [LIVES_W-1:0]   lives, lives_nxt;
    logic [HIT_CNT_W-1:0] hit_cnt, hit_cnt_nxt;
    logic [TIMER_W-1:0]   timer, timer_nxt;
    logic                 frame_hit;

    frame_overlap_counter #(
        .MIN_OVERLAP_PIXELS (MIN_OVERLAP_PIXELS)
    ) u_frame_overlap_counter (
        .clk                  (clk),
        .resetN               (resetN),
        .startOfFrame         (startOfFrame),
        .playerDrawingRequest (playerDrawingRequest),
        .towerDrawingRequest  (towerDrawingRequest),
        .restart              (restart),
        .frameHit             (frame_hit)
    );

    // State, lives, hit count and cooldown timer registers.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state   <= ALIVE;
            lives   <= LIVES_LOAD;
            hit_cnt <= '0;
            timer   <= '0;
        end else begin
            state   <= state_nxt;
            lives   <= lives_nxt;
            hit_cnt <= hit_cnt_nxt;
            timer   <= timer_nxt;
        end
    end

    // Next-state and hit pulse; restart overrides any evaluation this cycle.
    always_comb begin
        state_nxt   = state;
        lives_nxt   = lives;
        hit_cnt_nxt = hit_cnt;
        timer_nxt   = timer;
        collision   = 1'b0;
        if (restart) begin
            state_nxt   = ALIVE;
            lives_nxt   = LIVES_LOAD;
            hit_cnt_nxt = '0;
            timer_nxt   = '0;
        end else begin
            case (state)
                ALIVE: begin
                    if (frame_hit && !pause) begin
                        collision   = 1'b1;
                        lives_nxt   = lives - 1'b1;
                        hit_cnt_nxt = hit_cnt_inc(hit_cnt);
                        if (lives <= LIVES_ONE) begin
                            lives_nxt = '0;
                            state_nxt = GAME_OVER;
                            timer_nxt = '0;
                        end else begin
                            state_nxt = COOLDOWN;
                            timer_nxt = TIMER_LOAD;
                        end
                    end
                end
                COOLDOWN: begin
                    // The frame in which the timer expires is already ALIVE,
                    // so its predecessor's overlap is evaluated normally.
                    if (startOfFrame && !pause) begin
                        if (timer <= TIMER_ONE) begin
                            timer_nxt = '0;
                            state_nxt = ALIVE;
                        end else begin
                            timer_nxt = timer - 1'b1;
                        end
                    end
                end
                GAME_OVER: begin
                    state_nxt = GAME_OVER;
                end
                default: begin
                    state_nxt = ALIVE;
                end
            endcase
        end
    end

    assign livesLeft    = lives;
    assign hitCount     = hit_cnt;
    assign invulnerable = (state == COOLDOWN);
    assign gameOver     = (state == GAME_OVER);

`ifdef COLLISION_BLINK_EN
    localparam int BLINK_W = (BLINK_PERIOD > 1) ? $clog2(BLINK_PERIOD) : 1;
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_PERIOD - 1);

    logic [BLINK_W-1:0] blink_cnt;
    logic               blink_vis;

    // Blink phase: starts hidden on cooldown entry, toggles every BLINK_PERIOD unpaused frames.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            blink_cnt <= '0;
            blink_vis <= 1'b1;
        end else if (restart) begin
            blink_cnt <= '0;
            blink_vis <= 1'b1;
        end else if ((state == ALIVE) && (state_nxt == COOLDOWN)) begin
            blink_cnt <= '0;
            blink_vis <= 1'b0;
        end else if ((state == COOLDOWN) && startOfFrame && !pause) begin
            if (blink_cnt >= BLINK_LAST) begin
                blink_cnt <= '0;
                blink_vis <= ~blink_vis;
            end else begin
                blink_cnt <= blink_cnt + 1'b1;
            end
        end
    end

    assign playerVisible = (state == COOLDOWN) ? blink_vis : 1'b1;
`else
    // Blink disabled: sprite always visible. BLINK_PERIOD only folds into a constant.
    localparam bit BLINK_PERIOD_SET = (BLINK_PERIOD > 0);
    assign playerVisible = BLINK_PERIOD_SET | 1'b1;
`endif

endmodule

// File: tb/tb_player_tower_collision.sv
// Self-checking bench for player_tower_collision: frame-level reference model
// with randomized pixel placement, pause and restart.
module tb_player_tower_collision;

    localparam int LIVES_INIT = 3;
    localparam int MIN_OVL    = 4;
    localparam int INVULN     = 60;
    localparam int BLINK      = 8;
    localparam int FRAME_LEN  = 24;

    logic       clk = 1'b0;
    logic       resetN;
    logic       startOfFrame;
    logic       playerDrawingRequest;
    logic       towerDrawingRequest;
    logic       pause;
    logic       restart;
    logic       collision;
    logic [3:0] livesLeft;
    logic [7:0] hitCount;
    logic       invulnerable;
    logic       gameOver;
    logic       playerVisible;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model state (frame granularity).
    int m_lives;
    int m_hits;
    int m_cd;            // unpaused frames of invulnerability still owed
    int m_cd_frames;     // unpaused frame starts seen since cooldown entry
    int m_prev_cnt;      // overlap pixels of the frame that just ended
    bit m_go;

    always #5 clk = ~clk;

    player_tower_collision #(
        .LIVES_INIT         (LIVES_INIT),
        .MIN_OVERLAP_PIXELS (MIN_OVL),
        .INVULN_FRAMES      (INVULN),
        .BLINK_PERIOD       (BLINK)
    ) dut (
        .clk                  (clk),
        .resetN               (resetN),
        .startOfFrame         (startOfFrame),
        .playerDrawingRequest (playerDrawingRequest),
        .towerDrawingRequest  (towerDrawingRequest),
        .pause                (pause),
        .restart              (restart),
        .collision            (collision),
        .livesLeft            (livesLeft),
        .hitCount             (hitCount),
        .invulnerable         (invulnerable),
        .gameOver             (gameOver),
        .playerVisible        (playerVisible)
    );

    function automatic bit exp_vis();
`ifdef COLLISION_BLINK_EN
        if (m_cd > 0) return ((m_cd_frames / BLINK) % 2) != 0;
        return 1'b1;
`else
        return 1'b1;
`endif
    endfunction

    task automatic model_reset();
        m_lives     = LIVES_INIT;
        m_hits      = 0;
        m_cd        = 0;
        m_cd_frames = 0;
        m_prev_cnt  = 0;
        m_go        = 1'b0;
    endtask

    // One video frame: startOfFrame in cycle 0, n_ovl overlap pixels at random
    // positions, unrelated single-sprite pixels elsewhere. Every cycle is
    // compared against the model.
    task automatic run_frame(input int n_ovl, input bit p, input bit rs, output int coll_seen);
        bit ovl [FRAME_LEN];
        int placed;
        int pos;
        int cur;
        int n;
        bit hit;
        bit exp_coll;
        coll_seen = 0;
        hit       = 1'b0;
        cur       = 0;
        placed    = 0;
        n         = (n_ovl > FRAME_LEN - 1) ? FRAME_LEN - 1 : n_ovl;
        for (int j = 0; j < FRAME_LEN; j++) ovl[j] = 1'b0;
        while (placed < n) begin
            pos = $urandom_range(FRAME_LEN - 2, 0);
            if (!ovl[pos]) begin
                ovl[pos] = 1'b1;
                placed++;
            end
        end
        for (int j = 0; j < FRAME_LEN; j++) begin
            @(negedge clk);
            exp_coll = 1'b0;
            if (j == 1) begin
                if (rs) begin
                    m_lives = LIVES_INIT;
                    m_hits  = 0;
                    m_cd    = 0;
                    m_go    = 1'b0;
                end else begin
                    if (m_cd > 0 && !p) begin
                        m_cd_frames++;
                        m_cd--;
                    end
                    hit = (m_cd == 0) && !m_go && (m_prev_cnt >= MIN_OVL) && !p;
                end
                exp_coll = hit;
            end else if (j == 2 && hit) begin
                m_lives--;
                m_hits = (m_hits < 255) ? m_hits + 1 : 255;
                if (m_lives == 0) begin
                    m_go = 1'b1;
                end else begin
                    m_cd        = INVULN;
                    m_cd_frames = 0;
                end
            end
            vectors++;
            if (collision !== exp_coll) begin
                miscompares++;
                $display("FAIL collision cyc%0d: got %b want %b", j, collision, exp_coll);
            end
            vectors++;
            if (livesLeft !== 4'(m_lives)) begin
                miscompares++;
                $display("FAIL livesLeft cyc%0d: got %0d want %0d", j, livesLeft, m_lives);
            end
            vectors++;
            if (hitCount !== 8'(m_hits)) begin
                miscompares++;
                $display("FAIL hitCount cyc%0d: got %0d want %0d", j, hitCount, m_hits);
            end
            vectors++;
            if (invulnerable !== (m_cd > 0)) begin
                miscompares++;
                $display("FAIL invulnerable cyc%0d: got %b want %b", j, invulnerable, (m_cd > 0));
            end
            vectors++;
            if (gameOver !== m_go) begin
                miscompares++;
                $display("FAIL gameOver cyc%0d: got %b want %b", j, gameOver, m_go);
            end
            vectors++;
            if (playerVisible !== exp_vis()) begin
                miscompares++;
                $display("FAIL playerVisible cyc%0d: got %b want %b", j, playerVisible, exp_vis());
            end
            if (collision === 1'b1) coll_seen++;
            startOfFrame = (j == 0);
            restart      = rs && (j == 0);
            pause        = p;
            if (ovl[j]) begin
                playerDrawingRequest = 1'b1;
                towerDrawingRequest  = 1'b1;
            end else begin
                pos = $urandom_range(2, 0);
                playerDrawingRequest = (pos == 1);
                towerDrawingRequest  = (pos == 2);
            end
            if (ovl[j] && !(rs && j == 0)) cur++;
        end
        m_prev_cnt = cur;
    endtask

    task automatic check_static(input string tag, input logic [3:0] lives_w, input logic [7:0] hits_w,
                                input logic inv_w, input logic go_w);
        vectors++;
        if (livesLeft !== lives_w) begin
            miscompares++;
            $display("FAIL %s livesLeft: got %0d want %0d", tag, livesLeft, lives_w);
        end
        vectors++;
        if (hitCount !== hits_w) begin
            miscompares++;
            $display("FAIL %s hitCount: got %0d want %0d", tag, hitCount, hits_w);
        end
        vectors++;
        if (invulnerable !== inv_w) begin
            miscompares++;
            $display("FAIL %s invulnerable: got %b want %b", tag, invulnerable, inv_w);
        end
        vectors++;
        if (gameOver !== go_w) begin
            miscompares++;
            $display("FAIL %s gameOver: got %b want %b", tag, gameOver, go_w);
        end
    endtask

    task automatic test_reset();
        resetN               = 1'b0;
        startOfFrame         = 1'b0;
        playerDrawingRequest = 1'b0;
        towerDrawingRequest  = 1'b0;
        pause                = 1'b0;
        restart              = 1'b0;
        repeat (3) @(negedge clk);
        vectors++;
        if (collision !== 1'b0) begin
            miscompares++;
            $display("FAIL reset collision: got %b want 0", collision);
        end
        vectors++;
        if (playerVisible !== 1'b1) begin
            miscompares++;
            $display("FAIL reset playerVisible: got %b want 1", playerVisible);
        end
        check_static("reset", 4'd3, 8'd0, 1'b0, 1'b0);
        resetN = 1'b1;
        model_reset();
    endtask

    task automatic test_single_hit();
        int c;
        run_frame(10, 1'b0, 1'b0, c);
        run_frame(8, 1'b0, 1'b0, c);
        vectors++;
        if (c !== 1) begin
            miscompares++;
            $display("FAIL single_hit pulses: got %0d want 1", c);
        end
        check_static("single_hit", 4'd2, 8'd1, 1'b1, 1'b0);
    endtask

    task automatic test_invuln();
        int c;
        int total;
        total = 0;
        for (int f = 2; f <= 59; f++) begin
            run_frame(8, 1'b0, 1'b0, c);
            total += c;
        end
        run_frame(0, 1'b0, 1'b0, c);
        total += c;
        vectors++;
        if (total !== 0) begin
            miscompares++;
            $display("FAIL invuln pulses: got %0d want 0", total);
        end
        check_static("invuln_end", 4'd2, 8'd1, 1'b1, 1'b0);
        run_frame(8, 1'b0, 1'b0, c);
        check_static("invuln_expired", 4'd2, 8'd1, 1'b0, 1'b0);
        run_frame(0, 1'b0, 1'b0, c);
        vectors++;
        if (c !== 1) begin
            miscompares++;
            $display("FAIL second_hit pulses: got %0d want 1", c);
        end
        check_static("second_hit", 4'd1, 8'd2, 1'b1, 1'b0);
    endtask

    task automatic test_game_over();
        int c;
        int total;
        total = 0;
        for (int f = 0; f < INVULN; f++) begin
            run_frame(0, 1'b0, 1'b0, c);
            total += c;
        end
        run_frame(8, 1'b0, 1'b0, c);
        total += c;
        run_frame(0, 1'b0, 1'b0, c);
        total += c;
        vectors++;
        if (total !== 1) begin
            miscompares++;
            $display("FAIL third_hit pulses: got %0d want 1", total);
        end
        check_static("game_over", 4'd0, 8'd3, 1'b0, 1'b1);
        total = 0;
        for (int f = 0; f < 4; f++) begin
            run_frame(12, 1'b0, 1'b0, c);
            total += c;
        end
        vectors++;
        if (total !== 0) begin
            miscompares++;
            $display("FAIL game_over pulses: got %0d want 0", total);
        end
        check_static("game_over_hold", 4'd0, 8'd3, 1'b0, 1'b1);
        run_frame(3, 1'b0, 1'b1, c);
        vectors++;
        if (c !== 0) begin
            miscompares++;
            $display("FAIL restart pulses: got %0d want 0", c);
        end
        check_static("restart", 4'd3, 8'd0, 1'b0, 1'b0);
    endtask

    task automatic test_sub_threshold();
        int c;
        int total;
        total = 0;
        for (int f = 0; f < 10; f++) begin
            run_frame(MIN_OVL - 1, 1'b0, 1'b0, c);
            total += c;
        end
        vectors++;
        if (total !== 0) begin
            miscompares++;
            $display("FAIL sub_threshold pulses: got %0d want 0", total);
        end
        check_static("sub_threshold", 4'd3, 8'd0, 1'b0, 1'b0);
    endtask

    task automatic test_pause();
        int c;
        int total;
        total = 0;
        run_frame(20, 1'b1, 1'b0, c);
        total += c;
        run_frame(0, 1'b1, 1'b0, c);
        total += c;
        run_frame(0, 1'b0, 1'b0, c);
        total += c;
        vectors++;
        if (total !== 0) begin
            miscompares++;
            $display("FAIL pause pulses: got %0d want 0", total);
        end
        check_static("pause", 4'd3, 8'd0, 1'b0, 1'b0);
    endtask

    task automatic test_pause_cooldown();
        int c;
        run_frame(10, 1'b0, 1'b0, c);
        run_frame(0, 1'b0, 1'b0, c);
        check_static("pause_cd_hit", 4'd2, 8'd1, 1'b1, 1'b0);
        for (int f = 0; f < 30; f++) run_frame(8, 1'b1, 1'b0, c);
        for (int f = 0; f < INVULN - 1; f++) run_frame(0, 1'b0, 1'b0, c);
        check_static("pause_cd_held", 4'd2, 8'd1, 1'b1, 1'b0);
        run_frame(0, 1'b0, 1'b0, c);
        check_static("pause_cd_done", 4'd2, 8'd1, 1'b0, 1'b0);
    endtask

    task automatic test_reset_mid_cooldown();
        int c;
        run_frame(10, 1'b0, 1'b0, c);
        run_frame(0, 1'b0, 1'b0, c);
        for (int f = 0; f < 5; f++) run_frame(0, 1'b0, 1'b0, c);
        run_frame(12, 1'b0, 1'b0, c);
        @(negedge clk);
        resetN               = 1'b0;
        playerDrawingRequest = 1'b0;
        towerDrawingRequest  = 1'b0;
        #1;
        vectors++;
        if (collision !== 1'b0) begin
            miscompares++;
            $display("FAIL midreset collision: got %b want 0", collision);
        end
        vectors++;
        if (playerVisible !== 1'b1) begin
            miscompares++;
            $display("FAIL midreset playerVisible: got %b want 1", playerVisible);
        end
        check_static("midreset", 4'd3, 8'd0, 1'b0, 1'b0);
        @(negedge clk);
        resetN = 1'b1;
        model_reset();
        run_frame(0, 1'b0, 1'b0, c);
        run_frame(0, 1'b0, 1'b0, c);
        vectors++;
        if (c !== 0) begin
            miscompares++;
            $display("FAIL midreset stale count pulses: got %0d want 0", c);
        end
        check_static("after_midreset", 4'd3, 8'd0, 1'b0, 1'b0);
    endtask

    task automatic test_random();
        int c;
        int n;
        bit p;
        bit rs;
        for (int f = 0; f < 150; f++) begin
            n  = $urandom_range(8, 0);
            p  = ($urandom_range(7, 0) == 0);
            rs = ($urandom_range(39, 0) == 0);
            run_frame(n, p, rs, c);
        end
    endtask

    initial begin
        test_reset();
        test_single_hit();
        test_invuln();
        test_game_over();
        test_sub_threshold();
        test_pause();
        test_pause_cooldown();
        test_reset_mid_cooldown();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
